axi_lite_to_axi_bridge: RTL



---
 rtl/axi_lite_to_axi_bridge_pkg.sv | 132 +++++++++++++
 rtl/axi_lite_to_axi_bridge_slice.sv | 44 ++++
 rtl/axi_lite_to_axi_bridge.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_to_axi_bridge_pkg.sv
// Shared constants, helper functions and default channel types for the AXI-Lite to AXI4 bridge.
package axi_lite_to_axi_bridge_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [2:0] size_from_width(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_txns);
    return $clog2(max_txns + 1);
  endfunction

  // Default channel types for a 32-bit address/data, 4-bit ID, 1-bit user system
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } lite_ax_def_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } lite_w_def_t;

  typedef struct packed {
    logic [1:0] resp;
  } lite_b_def_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } lite_r_def_t;

  typedef struct packed {
    lite_ax_def_t aw;
    logic         aw_valid;
    lite_w_def_t  w;
    logic         w_valid;
    logic         b_ready;
    lite_ax_def_t ar;
    logic         ar_valid;
    logic         r_ready;
  } lite_req_def_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    lite_b_def_t b;
    logic        b_valid;
    logic        ar_ready;
    lite_r_def_t r;
    logic        r_valid;
  } lite_resp_def_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [0:0]  user;
  } full_aw_def_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } full_ar_def_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [0:0]  user;
  } full_w_def_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } full_b_def_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } full_r_def_t;

  typedef struct packed {
    full_aw_def_t aw;
    logic         aw_valid;
    full_w_def_t  w;
    logic         w_valid;
    logic         b_ready;
    full_ar_def_t ar;
    logic         ar_valid;
    logic         r_ready;
  } full_req_def_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    full_b_def_t b;
    logic        b_valid;
    logic        ar_ready;
    full_r_def_t r;
    logic        r_valid;
  } full_resp_def_t;

endpackage

// File: rtl/axi_lite_to_axi_bridge_slice.sv
// One-entry valid/ready register slice: one cycle latency, full throughput when draining.
module axi_lite_to_axi_bridge_slice
  import axi_lite_to_axi_bridge_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             full_q, full_d;
  logic [Width-1:0] data_q, data_d;

  assign ready_o = ~full_q | ready_i;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (ready_o) begin
      full_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign valid_o = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/axi_lite_to_axi_bridge.sv
// AXI4-Lite subordinate to AXI4 manager bridge with per-channel slices and outstanding limits.
// Optional protocol checker: define AXI_LITE_TO_AXI_BRIDGE_PROTO_CHECK_EN.
module axi_lite_to_axi_bridge
  import axi_lite_to_axi_bridge_pkg::*;
#(
  parameter int unsigned AxiAddrWidth    = 32,
  parameter int unsigned AxiDataWidth    = 32,
  parameter int unsigned AxiIdWidth      = 4,
  parameter int unsigned AxiUserWidth    = 1,
  parameter int unsigned AxiMaxWriteTxns = 4,
  parameter int unsigned AxiMaxReadTxns  = 4,
  parameter int unsigned AxiFixedId      = 0,
  parameter type lite_req_t  = lite_req_def_t,
  parameter type lite_resp_t = lite_resp_def_t,
  parameter type full_req_t  = full_req_def_t,
  parameter type full_resp_t = full_resp_def_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  lite_req_t  slv_req_i,
  output lite_resp_t slv_resp_o,
  output full_req_t  mst_req_o,
  input  full_resp_t mst_resp_i,
  output logic       proto_err_o
);

  localparam int unsigned WrCntW = cnt_width(AxiMaxWriteTxns);
  localparam int unsigned RdCntW = cnt_width(AxiMaxReadTxns);
  localparam logic [WrCntW-1:0] WrMax = WrCntW'(AxiMaxWriteTxns);
  localparam logic [RdCntW-1:0] RdMax = RdCntW'(AxiMaxReadTxns);
  localparam logic [AxiIdWidth-1:0] FixedId = AxiIdWidth'(AxiFixedId);

  full_req_t  mst_map;
  lite_resp_t slv_map;

  localparam int unsigned AwW = $bits(mst_map.aw);
  localparam int unsigned WW  = $bits(mst_map.w);
  localparam int unsigned ArW = $bits(mst_map.ar);
  localparam int unsigned BW  = $bits(slv_map.b);
  localparam int unsigned RW  = $bits(slv_map.r);

  if ($bits(mst_map.aw.addr) != AxiAddrWidth || $bits(mst_map.w.data) != AxiDataWidth ||
      $bits(mst_map.aw.id) != AxiIdWidth || $bits(mst_map.aw.user) != AxiUserWidth ||
      AxiMaxWriteTxns < 1 || AxiMaxReadTxns < 1) begin : g_bad_cfg
    $error("axi_lite_to_axi_bridge: channel types do not match width parameters");
  end

  always_comb begin
    mst_map           = '0;
    mst_map.aw.id     = FixedId;
    mst_map.aw.addr   = slv_req_i.aw.addr;
    mst_map.aw.prot   = slv_req_i.aw.prot;
    mst_map.aw.size   = size_from_width(AxiDataWidth);
    mst_map.aw.burst  = BURST_INCR;
    mst_map.w.data    = slv_req_i.w.data;
    mst_map.w.strb    = slv_req_i.w.strb;
    mst_map.w.last    = 1'b1;
    mst_map.ar.id     = FixedId;
    mst_map.ar.addr   = slv_req_i.ar.addr;
    mst_map.ar.prot   = slv_req_i.ar.prot;
    mst_map.ar.size   = size_from_width(AxiDataWidth);
    mst_map.ar.burst  = BURST_INCR;
    slv_map           = '0;
    slv_map.b.resp    = mst_resp_i.b.resp;
    slv_map.r.data    = mst_resp_i.r.data;
    slv_map.r.resp    = mst_resp_i.r.resp;
  end

  logic resp_unused;
  assign resp_unused = ^{mst_resp_i.b.id, mst_resp_i.b.user, mst_resp_i.r.id,
                         mst_resp_i.r.last, mst_resp_i.r.user, mst_map.aw_valid,
                         mst_map.w_valid, mst_map.b_ready, mst_map.ar_valid,
                         mst_map.r_ready, slv_map.aw_ready, slv_map.w_ready,
                         slv_map.b_valid, slv_map.ar_ready, slv_map.r_valid};

  logic           aw_ready_s, aw_valid_s, aw_drain;
  logic [AwW-1:0] aw_data_s;
  logic           w_ready_s, w_valid_s;
  logic [WW-1:0]  w_data_s;
  logic           ar_ready_s, ar_valid_s, ar_drain;
  logic [ArW-1:0] ar_data_s;
  logic           b_ready_s, b_valid_s;
  logic [BW-1:0]  b_data_s;
  logic           r_ready_s, r_valid_s;
  logic [RW-1:0]  r_data_s;

  logic [WrCntW-1:0] wr_cnt_q, wr_cnt_d;
  logic [RdCntW-1:0] rd_cnt_q, rd_cnt_d;
  logic wr_at_max, rd_at_max;
  logic mst_aw_valid, mst_ar_valid;
  logic aw_hs, ar_hs, slv_b_hs, slv_r_hs;

  assign wr_at_max    = (wr_cnt_q == WrMax);
  assign rd_at_max    = (rd_cnt_q == RdMax);
  // Gating holds the request inside the slice rather than dropping it
  assign mst_aw_valid = aw_valid_s & ~wr_at_max;
  assign mst_ar_valid = ar_valid_s & ~rd_at_max;
  assign aw_drain     = mst_resp_i.aw_ready & ~wr_at_max;
  assign ar_drain     = mst_resp_i.ar_ready & ~rd_at_max;

  axi_lite_to_axi_bridge_slice #(.Width(AwW)) i_aw_slice (
    .clk_i, .rst_ni,
    .valid_i(slv_req_i.aw_valid), .ready_o(aw_ready_s), .data_i(mst_map.aw),
    .valid_o(aw_valid_s), .ready_i(aw_drain), .data_o(aw_data_s)
  );

  axi_lite_to_axi_bridge_slice #(.Width(WW)) i_w_slice (
    .clk_i, .rst_ni,
    .valid_i(slv_req_i.w_valid), .ready_o(w_ready_s), .data_i(mst_map.w),
    .valid_o(w_valid_s), .ready_i(mst_resp_i.w_ready), .data_o(w_data_s)
  );

  axi_lite_to_axi_bridge_slice #(.Width(ArW)) i_ar_slice (
    .clk_i, .rst_ni,
    .valid_i(slv_req_i.ar_valid), .ready_o(ar_ready_s), .data_i(mst_map.ar),
    .valid_o(ar_valid_s), .ready_i(ar_drain), .data_o(ar_data_s)
  );

  axi_lite_to_axi_bridge_slice #(.Width(BW)) i_b_slice (
    .clk_i, .rst_ni,
    .valid_i(mst_resp_i.b_valid), .ready_o(b_ready_s), .data_i(slv_map.b),
    .valid_o(b_valid_s), .ready_i(slv_req_i.b_ready), .data_o(b_data_s)
  );

  axi_lite_to_axi_bridge_slice #(.Width(RW)) i_r_slice (
    .clk_i, .rst_ni,
    .valid_i(mst_resp_i.r_valid), .ready_o(r_ready_s), .data_i(slv_map.r),
    .valid_o(r_valid_s), .ready_i(slv_req_i.r_ready), .data_o(r_data_s)
  );

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw       = aw_data_s;
    mst_req_o.aw_valid = mst_aw_valid;
    mst_req_o.w        = w_data_s;
    mst_req_o.w_valid  = w_valid_s;
    mst_req_o.b_ready  = b_ready_s;
    mst_req_o.ar       = ar_data_s;
    mst_req_o.ar_valid = mst_ar_valid;
    mst_req_o.r_ready  = r_ready_s;
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready_s;
    slv_resp_o.w_ready  = w_ready_s;
    slv_resp_o.b        = b_data_s;
    slv_resp_o.b_valid  = b_valid_s;
    slv_resp_o.ar_ready = ar_ready_s;
    slv_resp_o.r        = r_data_s;
    slv_resp_o.r_valid  = r_valid_s;
  end

  assign aw_hs    = mst_aw_valid & mst_resp_i.aw_ready;
  assign ar_hs    = mst_ar_valid & mst_resp_i.ar_ready;
  assign slv_b_hs = b_valid_s & slv_req_i.b_ready;
  assign slv_r_hs = r_valid_s & slv_req_i.r_ready;

  // Responses with a zero count saturate; simultaneous inc/dec leaves the count unchanged
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (aw_hs && !slv_b_hs) wr_cnt_d = wr_cnt_q + 1'b1;
    else if (!aw_hs && slv_b_hs && wr_cnt_q != '0) wr_cnt_d = wr_cnt_q - 1'b1;
    rd_cnt_d = rd_cnt_q;
    if (ar_hs && !slv_r_hs) rd_cnt_d = rd_cnt_q + 1'b1;
    else if (!ar_hs && slv_r_hs && rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

`ifdef AXI_LITE_TO_AXI_BRIDGE_PROTO_CHECK_EN
  logic err_q, err_d, viol;

  assign viol = (slv_b_hs && wr_cnt_q == '0) ||
                (slv_r_hs && rd_cnt_q == '0) ||
                (mst_resp_i.b_valid && b_ready_s && mst_resp_i.b.id != FixedId) ||
                (mst_resp_i.r_valid && r_ready_s &&
                 (mst_resp_i.r.id != FixedId || !mst_resp_i.r.last));
  assign err_d = err_q | viol;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (viol) $error("axi_lite_to_axi_bridge: protocol violation on B/R channel");
    end
  end

  assign proto_err_o = err_q;
`else
  assign proto_err_o = 1'b0;
`endif

endmodule
